mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores).

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/arb_sat_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state encoding and byte-strobe constants.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    IF_DROP = 2'd3
  } arb_state_e;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with enable and async active-low clear.
// Used for the wait-cycle statistics, so it only exists when ARB_STATS_EN is defined.
`ifdef ARB_STATS_EN
module arb_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the data stage (data has priority).
// Optional ARB_STATS_EN adds per-requester saturating wait-cycle counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef ARB_STATS_EN
  output logic [31:0]           if_wait_cnt,
  output logic [31:0]           dm_wait_cnt,
`endif
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_flush,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_valid,
  output logic                  if_stall,
  input  logic                  dm_req,
  input  logic [DATA_W/8-1:0]   dm_we,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  dm_valid,
  output logic                  dm_stall,
  output logic                  mem_req,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [STRB_W-1:0]   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                regrant, if_ok, dm_ok;

  // Completion responses are combinational so the pipeline sees data in the mem_ready cycle.
  always_comb begin
    if_valid = (state_q == IF_BUSY) && mem_ready && !if_flush;
    dm_valid = (state_q == DM_BUSY) && mem_ready;
    if_rdata = if_valid ? mem_rdata : '0;
    dm_rdata = (dm_valid && (mem_we_q == '0)) ? mem_rdata : '0;
    if_stall = if_req && !if_valid;
    dm_stall = dm_req && !dm_valid;
  end

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    regrant     = 1'b0;
    if_ok       = 1'b1;
    dm_ok       = 1'b1;

    unique case (state_q)
      IDLE:    regrant = 1'b1;
      IF_BUSY: begin
        if (mem_ready) begin
          regrant = 1'b1;
          if_ok   = 1'b0;
        end else if (if_flush) begin
          state_d = IF_DROP;
        end
      end
      IF_DROP: begin
        regrant = mem_ready;
        if_ok   = 1'b0;
      end
      DM_BUSY: begin
        regrant = mem_ready;
        dm_ok   = 1'b0;
      end
    endcase

    // The requester that just completed is excluded so the other one gets the port directly.
    if (regrant) begin
      state_d = IDLE;
      if (dm_req && dm_ok) begin
        state_d     = DM_BUSY;
        mem_we_d    = dm_we;
        mem_addr_d  = dm_addr;
        mem_wdata_d = dm_wdata;
      end else if (if_req && !if_flush && if_ok) begin
        state_d    = IF_BUSY;
        mem_we_d   = '0;
        mem_addr_d = if_addr;
      end
    end

    mem_req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef ARB_STATS_EN
  arb_sat_counter #(.W(32)) u_if_wait_cnt (
    .clk (clk),
    .rst (rst),
    .en  (if_stall),
    .cnt (if_wait_cnt)
  );

  arb_sat_counter #(.W(32)) u_dm_wait_cnt (
    .clk (clk),
    .rst (rst),
    .en  (dm_stall),
    .cnt (dm_wait_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          if_req, if_flush, if_valid, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_valid, dm_stall;
  logic [SW-1:0] dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_req, mem_ready;
  logic [SW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
  logic [31:0]   if_wait_cnt, dm_wait_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ARB_STATS_EN
    .if_wait_cnt (if_wait_cnt),
    .dm_wait_cnt (dm_wait_cnt),
`endif
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .if_stall  (if_stall),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .dm_stall  (dm_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: who currently owns the memory and what was latched for them.
  typedef enum int {OWN_NONE, OWN_IF, OWN_DM} owner_e;
  owner_e        m_own;
  bit            m_drop;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_we;
  logic [DW-1:0] m_wdata;
  longint        m_if_wait, m_dm_wait;
  bit            e_if_valid, e_dm_valid;

  int            obs_mreq, obs_ifv, obs_dmv;
  logic [DW-1:0] obs_if_rdata;

  task automatic model_reset();
    m_own = OWN_NONE; m_drop = 0;
    m_addr = '0; m_we = '0; m_wdata = '0;
    m_if_wait = 0; m_dm_wait = 0;
    e_if_valid = 0; e_dm_valid = 0;
  endtask

  task automatic obs_clear();
    obs_mreq = 0; obs_ifv = 0; obs_dmv = 0; obs_if_rdata = '0;
  endtask

  task automatic compare();
    bit            done;
    logic [DW-1:0] e_ifr, e_dmr;
    done       = (m_own != OWN_NONE) && mem_ready;
    e_if_valid = done && (m_own == OWN_IF) && !m_drop && !if_flush;
    e_dm_valid = done && (m_own == OWN_DM);
    e_ifr      = e_if_valid ? mem_rdata : '0;
    e_dmr      = (e_dm_valid && (m_we == '0)) ? mem_rdata : '0;
    chk("mem_req",   mem_req,   m_own != OWN_NONE);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_we",    mem_we,    m_we);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_valid",  if_valid,  e_if_valid);
    chk("if_rdata",  if_rdata,  e_ifr);
    chk("dm_valid",  dm_valid,  e_dm_valid);
    chk("dm_rdata",  dm_rdata,  e_dmr);
    chk("if_stall",  if_stall,  if_req && !e_if_valid);
    chk("dm_stall",  dm_stall,  dm_req && !e_dm_valid);
`ifdef ARB_STATS_EN
    chk("if_wait_cnt", if_wait_cnt, m_if_wait);
    chk("dm_wait_cnt", dm_wait_cnt, m_dm_wait);
`endif
    if (mem_req)  obs_mreq++;
    if (if_valid) begin obs_ifv++; obs_if_rdata = if_rdata; end
    if (dm_valid) obs_dmv++;
  endtask

  task automatic advance();
    bit     done;
    owner_e excl;
    if (if_req && !e_if_valid && m_if_wait < 64'hFFFF_FFFF) m_if_wait++;
    if (dm_req && !e_dm_valid && m_dm_wait < 64'hFFFF_FFFF) m_dm_wait++;
    done = (m_own != OWN_NONE) && mem_ready;
    if (m_own == OWN_IF && if_flush) m_drop = 1;
    if (m_own == OWN_NONE || done) begin
      excl   = done ? m_own : OWN_NONE;
      m_own  = OWN_NONE;
      m_drop = 0;
      if (dm_req && excl != OWN_DM) begin
        m_own = OWN_DM; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
      end else if (if_req && !if_flush && excl != OWN_IF) begin
        m_own = OWN_IF; m_addr = if_addr; m_we = '0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_flush = 0; if_addr = '0;
    dm_req = 0; dm_we = '0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    do_reset();
    obs_clear();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    cycle();

    // Fetch only, memory answers on the 3rd request cycle.
    obs_clear();
    if_req = 1; if_addr = 32'h100;
    cycle();
    cycle();
    cycle();
    mem_ready = 1; mem_rdata = 32'h0050_0093;
    cycle();
    if_req = 0; mem_ready = 0;
    cycle();
    chk("t1_mreq_cycles", obs_mreq, 3);
    chk("t1_if_valid_cnt", obs_ifv, 1);
    chk("t1_if_rdata", obs_if_rdata, 32'h0050_0093);
    chk("t1_mem_addr", mem_addr, 32'h100);

    // Simultaneous fetch and load: data first, fetch follows with no idle cycle.
    obs_clear();
    if_req = 1; if_addr = 32'h104;
    dm_req = 1; dm_we = '0; dm_addr = 32'h2000; mem_ready = 1; mem_rdata = 32'h1111_1111;
    cycle();
    chk("t2_dm_first", dm_valid, 1);
    chk("t2_if_stall_a", if_stall, 1);
    cycle();
    dm_req = 0;
    chk("t2_if_direct", mem_req, 1);
    chk("t2_if_addr", mem_addr, 32'h104);
    mem_rdata = 32'h2222_2222;
    cycle();
    if_req = 0; mem_ready = 0;
    cycle();
    chk("t2_if_valid_cnt", obs_ifv, 1);
    chk("t2_dm_valid_cnt", obs_dmv, 1);

    // Half-word store.
    obs_clear();
    dm_req = 1; dm_we = STRB_HALF; dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF;
    cycle();
    chk("t3_mem_we", mem_we, 4'b0011);
    chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t3_mem_addr", mem_addr, 32'h2004);
    mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("t3_dm_valid", dm_valid, 1);
    chk("t3_dm_rdata", dm_rdata, 0);
    cycle();
    dm_req = 0; mem_ready = 0;
    cycle();
    chk("t3_dm_valid_cnt", obs_dmv, 1);

    // Flush during a fetch: result dropped, then the new target is fetched.
    obs_clear();
    if_req = 1; if_addr = 32'h108;
    cycle();
    cycle();
    if_flush = 1; if_addr = 32'h200;
    cycle();
    if_flush = 0;
    cycle();
    chk("t4_addr_held", mem_addr, 32'h108);
    chk("t4_req_held", mem_req, 1);
    mem_ready = 1;
    cycle();
    mem_ready = 0;
    cycle();
    chk("t4_new_addr", mem_addr, 32'h200);
    mem_ready = 1; mem_rdata = 32'h0000_0033;
    cycle();
    if_req = 0; mem_ready = 0;
    cycle();
    chk("t4_if_valid_cnt", obs_ifv, 1);
    chk("t4_if_rdata", obs_if_rdata, 32'h33);

    // Asynchronous reset in the middle of a data transaction.
    obs_clear();
    dm_req = 1; dm_we = STRB_WORD; dm_addr = 32'h2008; dm_wdata = 32'h1234_5678;
    cycle();
    cycle();
    mem_ready = 1;
    #2 rst = 1'b0;
    #1;
    chk("t5_mem_req", mem_req, 0);
    chk("t5_mem_we", mem_we, 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_dm_valid", dm_valid, 0);
    chk("t5_if_valid", if_valid, 0);
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    obs_clear();
    cycle();
    cycle();
    chk("t5_no_spurious", obs_ifv + obs_dmv, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (!if_req || e_if_valid || ($urandom % 40 == 0)) begin
        if_req  = ($urandom % 3 != 0);
        if_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if_flush = ($urandom % 8 == 0);
      if (if_flush) if_addr = 32'h400 + (32'($urandom_range(0, 255)) << 2);
      if (!dm_req || e_dm_valid || ($urandom % 40 == 0)) begin
        dm_req   = ($urandom % 3 == 0);
        dm_addr  = 32'h2000 + (32'($urandom_range(0, 63)) << 2);
        dm_wdata = $urandom;
        case ($urandom % 4)
          0:       dm_we = '0;
          1:       dm_we = STRB_BYTE;
          2:       dm_we = STRB_HALF;
          default: dm_we = STRB_WORD;
        endcase
      end
      mem_ready = ($urandom % 3 != 0);
      mem_rdata = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
